fifo_sync_flags: RTL and testbench

//  Single-clock FIFO, parametrised in width, depth and read mode; next generation of the dual-clock FIFO.

---
 rtl/fifo_sync_flags_if.sv | 30 +++
 rtl/fifo_sync_flags.sv | 130 +++++++++++++
 tb/tb_fifo_sync_flags.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fifo_sync_flags_if.sv
// Handshake bundle for fifo_sync_flags: write side, read side, fill level and error flags.
// The producer/consumer holds the master modport and the FIFO holds the slave modport.
interface fifo_sync_flags_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 6
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   level;
  logic             clr_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output wdata, winc, rinc, clr_err,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty, level, overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc, clr_err,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// optional first-word-fall-through read port and sticky overflow/underflow flags.
module fifo_sync_flags #(
  parameter int DSIZE     = 16,
  parameter int ASIZE     = 6,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_sync_flags_if.slave bus
);
  localparam int DEPTH = 1 << ASIZE;

  generate
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_sync_flags: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_flags: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("fifo_sync_flags: FWFT must be 0 or 1");
    end
  endgenerate

  localparam logic [ASIZE:0] DEPTH_LVL = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AF_LVL    = AF_THRESH[ASIZE:0];
  localparam logic [ASIZE:0] AE_LVL    = AE_THRESH[ASIZE:0];

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr_reg;
  logic [ASIZE:0] rptr_reg;
  logic [ASIZE:0] level_reg;
  logic [ASIZE:0] level_next;
  logic           overflow_reg;
  logic           underflow_reg;

  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;

  // Flags are decoded from the registered level only, so they reflect the state at cycle start.
  assign full  = (level_reg == DEPTH_LVL);
  assign empty = (level_reg == '0);
  assign wr_en = bus.winc && !full;
  assign rd_en = bus.rinc && !empty;

  always_comb begin
    level_next = level_reg;
    case ({wr_en, rd_en})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (rd_en) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      level_reg <= level_next;
      // A set in the same cycle as clr_err takes priority over the clear.
      if (bus.winc && full) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (bus.rinc && empty) begin
        underflow_reg <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_reg[ASIZE-1:0]] <= bus.wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty so reset shows rdata=0.
      assign bus.rdata  = empty ? '0 : mem[rptr_reg[ASIZE-1:0]];
      assign bus.rvalid = !empty;
    end else begin : g_std
      logic [DSIZE-1:0] rdata_reg;
      logic             rvalid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rd_en;
          if (rd_en) begin
            rdata_reg <= mem[rptr_reg[ASIZE-1:0]];
          end
        end
      end

      assign bus.rdata  = rdata_reg;
      assign bus.rvalid = rvalid_reg;
    end
  endgenerate

  assign bus.level         = level_reg;
  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.walmost_full  = (level_reg >= AF_LVL);
  assign bus.ralmost_empty = (level_reg <= AE_LVL);
  assign bus.overflow      = overflow_reg;
  assign bus.underflow     = underflow_reg;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: a standard-read and an FWFT instance driven identically and
// compared every cycle against a queue-based model of the FIFO behaviour.
module tb_fifo_sync_flags;
  localparam int DSIZE = 16;
  localparam int ASIZE = 6;
  localparam int DEPTH = 1 << ASIZE;
  localparam int AF    = 56;
  localparam int AE    = 8;

  logic clk;
  logic rst_n;

  fifo_sync_flags_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if0 ();
  fifo_sync_flags_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if1 ();

  fifo_sync_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE))
    u_dut_std (.clk(clk), .rst_n(rst_n), .bus(if0));
  fifo_sync_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE))
    u_dut_fwft (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DSIZE-1:0] q[$];
  bit               m_ovf;
  bit               m_unf;
  logic [DSIZE-1:0] m_rdata0;
  bit               m_rvalid0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf     = 0;
    m_unf     = 0;
    m_rdata0  = '0;
    m_rvalid0 = 0;
  endtask

  task automatic check_all(input string phase);
    int sz;
    sz = q.size();
    chk({phase, ".level"},   32'(if0.level), 32'(sz));
    chk({phase, ".wfull"},   32'(if0.wfull), 32'(sz == DEPTH));
    chk({phase, ".afull"},   32'(if0.walmost_full), 32'(sz >= AF));
    chk({phase, ".rempty"},  32'(if0.rempty), 32'(sz == 0));
    chk({phase, ".aempty"},  32'(if0.ralmost_empty), 32'(sz <= AE));
    chk({phase, ".ovf"},     32'(if0.overflow), 32'(m_ovf));
    chk({phase, ".unf"},     32'(if0.underflow), 32'(m_unf));
    chk({phase, ".rvalid0"}, 32'(if0.rvalid), 32'(m_rvalid0));
    chk({phase, ".rdata0"},  32'(if0.rdata), 32'(m_rdata0));
    chk({phase, ".level1"},  32'(if1.level), 32'(sz));
    chk({phase, ".ovf1"},    32'(if1.overflow), 32'(m_ovf));
    chk({phase, ".unf1"},    32'(if1.underflow), 32'(m_unf));
    chk({phase, ".rvalid1"}, 32'(if1.rvalid), 32'(sz > 0));
    chk({phase, ".rdata1"},  32'(if1.rdata), (sz > 0) ? 32'(q[0]) : 32'h0);
  endtask

  // One clock cycle: drive requests, let the edge happen, advance the model, compare.
  task automatic step(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit c,
                      input string phase);
    int  sz;
    bit  wa;
    bit  ra;
    if0.winc = w; if0.wdata = d; if0.rinc = r; if0.clr_err = c;
    if1.winc = w; if1.wdata = d; if1.rinc = r; if1.clr_err = c;
    @(posedge clk);
    sz = q.size();
    wa = w && (sz < DEPTH);
    ra = r && (sz > 0);
    if (w && sz == DEPTH) m_ovf = 1;
    else if (c)           m_ovf = 0;
    if (r && sz == 0)     m_unf = 1;
    else if (c)           m_unf = 0;
    m_rvalid0 = ra;
    if (ra) m_rdata0 = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    check_all(phase);
  endtask

  task automatic async_reset(input string phase);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(phase);
    @(posedge clk);
    #1;
    check_all({phase, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    bit w;
    bit r;
    int wprob;
    rst_n = 1'b0;
    if0.winc = 0; if0.wdata = '0; if0.rinc = 0; if0.clr_err = 0;
    if1.winc = 0; if1.wdata = '0; if1.rinc = 0; if1.clr_err = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Fill to full with 0..63
    for (int i = 0; i < DEPTH; i++) step(1, DSIZE'(i), 0, 0, "fill");
    // Write while full, then clear the sticky flag
    step(1, 16'hDEAD, 0, 0, "ovf");
    step(0, '0, 0, 1, "clr_ovf");
    // Drain in order, then one read too many
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0, "drain");
    step(0, '0, 0, 0, "idle");
    step(0, '0, 1, 0, "unf");
    // Set and clear together: set must win
    step(0, '0, 1, 1, "unf_set_wins");
    step(0, '0, 0, 1, "clr_unf");

    // Level 10, simultaneous traffic for 20 cycles
    for (int i = 0; i < 10; i++) step(1, DSIZE'(16'h100 + i), 0, 0, "to10");
    for (int i = 0; i < 20; i++) step(1, DSIZE'(16'h200 + i), 1, 0, "both");
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0, "drain10");
    step(1, 16'h0BAD, 1, 0, "both_empty");
    step(0, '0, 1, 1, "pop_clr");

    // FWFT word appears with no rinc, then pop leaves the FIFO empty
    step(1, 16'h1234, 0, 0, "fwft_wr");
    step(0, '0, 0, 0, "fwft_hold");
    step(0, '0, 1, 0, "fwft_pop");

    // Asynchronous reset mid-burst at level 30
    for (int i = 0; i < 30; i++) step(1, DSIZE'($urandom), 0, 0, "to30");
    async_reset("arst");
    step(1, 16'h5A5A, 0, 0, "post_rst_wr");
    step(0, '0, 1, 0, "post_rst_rd");

    // Randomized traffic with a drifting write bias so the FIFO visits full and empty
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) wprob = $urandom_range(10, 90);
      w = ($urandom_range(0, 99) < wprob);
      r = ($urandom_range(0, 99) < (100 - wprob));
      step(w, DSIZE'($urandom), r, ($urandom_range(0, 15) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
